rcc_byte_framer: RTL and testbench



---
 rtl/rcc_byte_framer_pkg.sv | 22 ++
 rtl/rcc_byte_framer_if.sv | 32 +++
 rtl/rcc_byte_framer_fifo.sv | 61 ++++++
 rtl/rcc_byte_framer.sv | 160 ++++++++++++++++
 tb/tb_rcc_byte_framer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rcc_byte_framer_pkg.sv
// Shared types and constants for the RCC byte framer.
package rcc_framer_pkg;

  // Framer sequencing: header bytes, payload, then checksum.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SOF     = 3'd1,
    LEN_HI  = 3'd2,
    LEN_LO  = 3'd3,
    PAYLOAD = 3'd4,
    CHK     = 3'd5
  } framer_state_t;

  localparam logic [7:0] SOF_DEFAULT    = 8'hA5;
  localparam int         RCC_WORD_BYTES = 4;

  // Payload length in bytes for a buffer length given in 32-bit words.
  function automatic logic [15:0] frame_len_bytes(input logic [5:0] words);
    return 16'(words) * 16'(RCC_WORD_BYTES);
  endfunction

endpackage

// File: rtl/rcc_byte_framer_if.sv
// Byte-stream interface of the framer: serialized input strobe plus the
// framed output link.
//
// Handshake: i_byte/i_byte_valid is a one-cycle strobe with no backpressure.
// On the output link a byte transfers on every rising clock edge where
// o_byte_valid && i_byte_ready; while o_byte_valid is high and i_byte_ready
// is low, o_byte and o_byte_valid are held unchanged by the framer.
interface rcc_byte_framer_if;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       i_byte_ready;

  // Framer side.
  modport master (
    input  i_byte,
    input  i_byte_valid,
    input  i_byte_ready,
    output o_byte,
    output o_byte_valid
  );

  // Serializer / downstream link side.
  modport slave (
    output i_byte,
    output i_byte_valid,
    output i_byte_ready,
    input  o_byte,
    input  o_byte_valid
  );
endinterface

// File: rtl/rcc_byte_framer_fifo.sv
// Single-clock show-ahead byte FIFO. dout always presents the head entry;
// a push on a full FIFO and a pop on an empty one are ignored.
module rcc_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come straight from the registered count, so a same-cycle
  // pop never frees room for a push.
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcc_byte_framer.sv
// Buffers the serializer byte stream and wraps each RCC buffer of payload
// into SOF, 16-bit length, payload, 8-bit checksum on a ready/valid link.
module rcc_byte_framer
  import rcc_framer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 64,
  parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic [5:0]                  i_RCC_BUFFER_LENGTH,
  rcc_byte_framer_if.master           link,
  output logic                        o_frame_active,
  output logic                        o_overflow,
  output logic [15:0]                 o_frame_count,
  output framer_state_t               dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);

  framer_state_t state;
  logic [15:0]   frame_len;
  logic [15:0]   remaining;
  logic [7:0]    sum;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          accept;
  logic          slot_free;

  assign fifo_push = link.i_byte_valid && !fifo_full;
  assign accept    = link.o_byte_valid && link.i_byte_ready;
  // Output register can take a new byte: either empty or being drained now.
  assign slot_free = !link.o_byte_valid || link.i_byte_ready;
  assign dbg_state = state;

  rcc_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (link.i_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_fifo_count)
  );

  // FIFO read: discard in IDLE for zero-length buffers, otherwise pop exactly
  // when a payload byte is moved from the FIFO head into the output register.
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      IDLE:    fifo_pop = !fifo_empty && (i_RCC_BUFFER_LENGTH == '0);
      LEN_LO:  fifo_pop = accept && !fifo_empty;
      PAYLOAD: fifo_pop = slot_free && (remaining != '0) && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  // Sticky overflow: a strobe arrived while the FIFO was already full.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      o_overflow <= 1'b0;
    end else if (link.i_byte_valid && fifo_full) begin
      o_overflow <= 1'b1;
    end
  end

  // Frame sequencer with registered output byte/valid. In PAYLOAD, remaining
  // counts bytes still to be loaded from the FIFO; once it is zero the next
  // free output slot means the last payload byte was accepted.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state             <= IDLE;
      frame_len         <= '0;
      remaining         <= '0;
      sum               <= '0;
      link.o_byte       <= 8'h00;
      link.o_byte_valid <= 1'b0;
      o_frame_active    <= 1'b0;
      o_frame_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && (i_RCC_BUFFER_LENGTH != '0)) begin
            frame_len         <= frame_len_bytes(i_RCC_BUFFER_LENGTH);
            sum               <= 8'h00;
            state             <= SOF;
            link.o_byte       <= SOF_BYTE;
            link.o_byte_valid <= 1'b1;
            o_frame_active    <= 1'b1;
          end
        end
        SOF: begin
          if (accept) begin
            state       <= LEN_HI;
            link.o_byte <= frame_len[15:8];
            sum         <= sum + frame_len[15:8];
          end
        end
        LEN_HI: begin
          if (accept) begin
            state       <= LEN_LO;
            link.o_byte <= frame_len[7:0];
            sum         <= sum + frame_len[7:0];
          end
        end
        LEN_LO: begin
          if (accept) begin
            state             <= PAYLOAD;
            remaining         <= frame_len;
            link.o_byte_valid <= 1'b0;
            if (fifo_pop) begin
              link.o_byte       <= fifo_dout;
              link.o_byte_valid <= 1'b1;
              sum               <= sum + fifo_dout;
              remaining         <= frame_len - 16'd1;
            end
          end
        end
        PAYLOAD: begin
          if (slot_free) begin
            if (remaining == '0) begin
              state             <= CHK;
              link.o_byte       <= 8'h00 - sum;
              link.o_byte_valid <= 1'b1;
            end else if (fifo_pop) begin
              link.o_byte       <= fifo_dout;
              link.o_byte_valid <= 1'b1;
              sum               <= sum + fifo_dout;
              remaining         <= remaining - 16'd1;
            end else begin
              // FIFO ran dry mid-payload: bubble until data arrives.
              link.o_byte_valid <= 1'b0;
            end
          end
        end
        CHK: begin
          if (accept) begin
            state             <= IDLE;
            link.o_byte_valid <= 1'b0;
            o_frame_active    <= 1'b0;
            o_frame_count     <= o_frame_count + 16'd1;
          end
        end
        default: begin
          state             <= IDLE;
          link.o_byte_valid <= 1'b0;
          o_frame_active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_byte_framer.sv
// Self-checking bench for rcc_byte_framer.
module tb_rcc_byte_framer;
  import rcc_framer_pkg::*;

  localparam int DEPTH = 16;

  logic          CLK;
  logic          RESETn;
  logic [5:0]    len;
  logic          frame_active;
  logic          overflow;
  logic [15:0]   frame_count;
  framer_state_t dbg_state;
  logic [4:0]    dbg_fifo_count;

  rcc_byte_framer_if bus ();

  rcc_byte_framer #(
    .FIFO_DEPTH (DEPTH),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .CLK                 (CLK),
    .RESETn              (RESETn),
    .i_RCC_BUFFER_LENGTH (len),
    .link                (bus),
    .o_frame_active      (frame_active),
    .o_overflow          (overflow),
    .o_frame_count       (frame_count),
    .dbg_state           (dbg_state),
    .dbg_fifo_count      (dbg_fifo_count)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] pay_q[$];
  int         acc_log[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Downstream ready pattern, updated just after each rising edge.
  initial begin
    bus.i_byte_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       bus.i_byte_ready = 1'b1;
        1:       bus.i_byte_ready = ~bus.i_byte_ready;
        default: bus.i_byte_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    logic [7:0] e;
    cyc = cyc + 1;
    if (!RESETn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        total = total + 1;
        if (bus.o_byte_valid !== 1'b1 || bus.o_byte !== prev_byte) begin
          bad = bad + 1;
          $display("FAIL hold: got valid=%b byte=%h want valid=1 byte=%h", bus.o_byte_valid, bus.o_byte, prev_byte);
        end
      end
      if (bus.o_byte_valid === 1'b1 && bus.i_byte_ready === 1'b1) begin
        acc_log.push_back(cyc);
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_byte: got %h want nothing", bus.o_byte);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_byte !== e) begin
            bad = bad + 1;
            $display("FAIL out_byte: got %h want %h", bus.o_byte, e);
          end
        end
      end
      prev_hold = bus.o_byte_valid && !bus.i_byte_ready;
      prev_byte = bus.o_byte;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    exp_q.delete();
    acc_log.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_fixed(input logic [7:0] first, input int n);
    logic [7:0] b;
    pay_q.delete();
    b = first;
    for (int i = 0; i < n; i++) begin
      pay_q.push_back(b);
      src_q.push_back(b);
      b = b + 8'd1;
    end
  endtask

  task automatic fill_random(input int n);
    logic [7:0] b;
    pay_q.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      pay_q.push_back(b);
      src_q.push_back(b);
    end
  endtask

  // Reference model of one frame: header, payload, two's-complement checksum.
  task automatic expect_frame(input logic [5:0] words);
    logic [15:0] l;
    logic [7:0]  s;
    l = {8'h00, words, 2'b00};
    exp_q.push_back(8'hA5);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    s = 8'(l[15:8] + l[7:0]);
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      s = 8'(s + pay_q[i]);
    end
    exp_q.push_back(8'(8'h00 - s));
  endtask

  // Strobes every byte of src_q, with 'gap' idle cycles between strobes.
  task automatic send_bytes(input int gap);
    while (src_q.size() > 0) begin
      bus.i_byte       = src_q.pop_front();
      bus.i_byte_valid = 1'b1;
      @(posedge CLK);
      #1;
      bus.i_byte_valid = 1'b0;
      repeat (gap) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s_drain: got %0d bytes outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_state(input framer_state_t s, input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state != s && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    total = total + 1;
    if (dbg_state != s) begin
      bad = bad + 1;
      $display("FAIL %s_wait: got state %0d want %0d", name, dbg_state, s);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESETn           = 1'b0;
    len              = 6'd0;
    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;
    #3;
    total = total + 1;
    if (bus.o_byte !== 8'h00 || bus.o_byte_valid !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_out: got %h/%b want 00/0", bus.o_byte, bus.o_byte_valid);
    end
    total = total + 1;
    if (frame_active !== 1'b0 || overflow !== 1'b0 || frame_count !== 16'd0) begin
      bad = bad + 1;
      $display("FAIL reset_status: got act=%b ovf=%b cnt=%0d want 0/0/0", frame_active, overflow, frame_count);
    end
    total = total + 1;
    if (dbg_state !== IDLE || dbg_fifo_count !== 5'd0) begin
      bad = bad + 1;
      $display("FAIL reset_state: got st=%0d fifo=%0d want 0/0", dbg_state, dbg_fifo_count);
    end
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total = total + 1;
    if (bus.o_byte_valid !== 1'b0 || dbg_state !== IDLE) begin
      bad = bad + 1;
      $display("FAIL reset_idle: got valid=%b st=%0d want 0/0", bus.o_byte_valid, dbg_state);
    end
  endtask

  task automatic test_basic();
    do_reset();
    ready_mode = 0;
    len = 6'd1;
    fill_fixed(8'h31, 4);
    expect_frame(6'd1);
    send_bytes(1);
    wait_drain(200, "basic");
    total = total + 1;
    if (frame_count !== 16'd1) begin
      bad = bad + 1;
      $display("FAIL basic_count: got %0d want 1", frame_count);
    end
    total = total + 1;
    if (frame_active !== 1'b0 || dbg_fifo_count !== 5'd0 || overflow !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL basic_end: got act=%b fifo=%0d ovf=%b want 0/0/0", frame_active, dbg_fifo_count, overflow);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1;
    len = 6'd1;
    fill_fixed(8'h31, 4);
    expect_frame(6'd1);
    send_bytes(0);
    wait_drain(200, "bp");
    ready_mode = 0;
    total = total + 1;
    if (frame_count !== 16'd1) begin
      bad = bad + 1;
      $display("FAIL bp_count: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] kept[$];
    do_reset();
    ready_mode = 2;
    len = 6'd8;
    @(posedge CLK);
    #1;
    fill_random(20);
    kept = pay_q[0:15];
    send_bytes(0);
    total = total + 1;
    if (dbg_fifo_count !== 5'd16 || overflow !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL ovf_fill: got fifo=%0d ovf=%b want 16/1", dbg_fifo_count, overflow);
    end
    total = total + 1;
    if (dbg_state !== SOF || bus.o_byte !== 8'hA5 || frame_active !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL ovf_sof: got st=%0d byte=%h act=%b want 1/a5/1", dbg_state, bus.o_byte, frame_active);
    end
    fill_random(16);
    pay_q = {kept, pay_q};
    expect_frame(6'd8);
    ready_mode = 0;
    repeat (8) begin
      @(posedge CLK);
      #1;
    end
    send_bytes(1);
    wait_drain(400, "ovf");
    total = total + 1;
    if (overflow !== 1'b1 || frame_count !== 16'd1) begin
      bad = bad + 1;
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d want 1/1", overflow, frame_count);
    end
  endtask

  task automatic test_zero_length();
    do_reset();
    ready_mode = 0;
    len = 6'd0;
    fill_random(4);
    send_bytes(0);
    @(posedge CLK);
    #1;
    total = total + 1;
    if (dbg_fifo_count !== 5'd0) begin
      bad = bad + 1;
      $display("FAIL zero_drain: got fifo=%0d want 0", dbg_fifo_count);
    end
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    total = total + 1;
    if (overflow !== 1'b0 || frame_count !== 16'd0 || dbg_state !== IDLE || frame_active !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL zero_status: got ovf=%b cnt=%0d st=%0d act=%b want 0/0/0/0", overflow, frame_count, dbg_state, frame_active);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_mode = 0;
    len = 6'd2;
    fill_fixed(8'h01, 8);
    expect_frame(6'd2);
    send_bytes(0);
    wait_state(PAYLOAD, 50, "b2b_payload");
    len = 6'd1;
    fill_random(4);
    expect_frame(6'd1);
    send_bytes(0);
    wait_drain(300, "b2b");
    total = total + 1;
    if (frame_count !== 16'd2) begin
      bad = bad + 1;
      $display("FAIL b2b_count: got %0d want 2", frame_count);
    end
    total = total + 1;
    if (acc_log.size() < 13) begin
      bad = bad + 1;
      $display("FAIL b2b_gap: got %0d accepts want at least 13", acc_log.size());
    end else if (acc_log[12] - acc_log[11] != 2) begin
      bad = bad + 1;
      $display("FAIL b2b_gap: got %0d cycles CHK->SOF want 2", acc_log[12] - acc_log[11]);
    end
  endtask

  task automatic test_reset_mid_frame();
    ready_mode = 0;
    len = 6'd4;
    fill_random(16);
    expect_frame(6'd4);
    while (src_q.size() > 8) void'(src_q.pop_back());
    send_bytes(0);
    wait_state(PAYLOAD, 50, "rst_payload");
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    RESETn = 1'b0;
    #1;
    total = total + 1;
    if (bus.o_byte !== 8'h00 || bus.o_byte_valid !== 1'b0 || frame_active !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL rst_async_out: got %h/%b/%b want 00/0/0", bus.o_byte, bus.o_byte_valid, frame_active);
    end
    total = total + 1;
    if (frame_count !== 16'd0 || overflow !== 1'b0 || dbg_fifo_count !== 5'd0 || dbg_state !== IDLE) begin
      bad = bad + 1;
      $display("FAIL rst_async_state: got cnt=%0d ovf=%b fifo=%0d st=%0d want 0/0/0/0", frame_count, overflow, dbg_fifo_count, dbg_state);
    end
    total = total + 1;
    if (exp_q.size() == 0) begin
      bad = bad + 1;
      $display("FAIL rst_aborted: got 0 bytes outstanding want checksum still pending");
    end
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    total = total + 1;
    if (dbg_state !== IDLE || dbg_fifo_count !== 5'd0 || bus.o_byte_valid !== 1'b0 || frame_count !== 16'd0) begin
      bad = bad + 1;
      $display("FAIL rst_after: got st=%0d fifo=%0d valid=%b cnt=%0d want 0/0/0/0", dbg_state, dbg_fifo_count, bus.o_byte_valid, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero_length();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
